// File: rtl/sync_req_arbiter.sv
// Round-robin REQ/ACK arbiter sharing one service resource across NUM_CH channels.
// Optional abort of a stalled service is enabled by defining ARB_TIMEOUT_EN.
module sync_req_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] REQ,
  output logic [NUM_CH-1:0] ACK,
  output logic [NUM_CH-1:0] GNT,
  output logic              SVC_START,
  output logic [ID_W-1:0]   SVC_ID,
  input  logic              SVC_DONE,
  output logic              BUSY,
  output logic              ERR
);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic                start_q, start_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     rr_q, rr_d;

  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic [ID_W-1:0]     pick_off;
  logic [ID_W:0]       pick_sum;
  logic [ID_W-1:0]     pick;
  logic [ID_W:0]       rr_sum;
  logic [ID_W-1:0]     rr_next;
  logic                tmo_expired;

  // Rotate requests so bit 0 is the rr pointer, then take the lowest set bit.
  always_comb begin
    req_dbl  = {REQ, REQ} >> rr_q;
    req_rot  = req_dbl[NUM_CH-1:0];
    pick_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_off = ID_W'(i);
    end
    pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    if (pick_sum >= (ID_W+1)'(NUM_CH)) pick_sum = pick_sum - (ID_W+1)'(NUM_CH);
    pick = pick_sum[ID_W-1:0];

    rr_sum = {1'b0, id_q} + (ID_W+1)'(1);
    if (rr_sum >= (ID_W+1)'(NUM_CH)) rr_sum = '0;
    rr_next = rr_sum[ID_W-1:0];
  end

`ifdef ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_expired = (state_q == WAIT_DONE) && !SVC_DONE &&
                       (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (state_q == WAIT_DONE && !SVC_DONE) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_expired) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  localparam int unused_tmo_cfg = TIMEOUT + TMO_W;
  assign tmo_expired = 1'b0;
  assign ERR         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    start_d = 1'b0;
    id_d    = id_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          start_d      = 1'b1;
          id_d         = pick;
          busy_d       = 1'b1;
          state_d      = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (SVC_DONE || tmo_expired) begin
          gnt_d       = '0;
          ack_d       = '0;
          ack_d[id_q] = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        // An aborted requester has REQ low already, so ACK lasts one cycle.
        if (!REQ[id_q]) begin
          ack_d   = '0;
          busy_d  = 1'b0;
          rr_d    = rr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
    end
  end

  assign GNT       = gnt_q;
  assign ACK       = ack_q;
  assign SVC_START = start_q;
  assign SVC_ID    = id_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Scoreboard bench for sync_req_arbiter: expected grant order is queued when
// requests are raised and compared when SVC_START is observed.
module tb_sync_req_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = '0;
  logic [3:0] ACK;
  logic [3:0] GNT;
  logic       SVC_START;
  logic [1:0] SVC_ID;
  logic       SVC_DONE = 1'b0;
  logic       BUSY;
  logic       ERR;

  int n_checks = 0;
  int n_fails  = 0;
  logic [1:0] exp_q[$];

  sync_req_arbiter #(.NUM_CH(4), .ID_W(2), .TIMEOUT(8), .TMO_W(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .ACK(ACK), .GNT(GNT),
    .SVC_START(SVC_START), .SVC_ID(SVC_ID), .SVC_DONE(SVC_DONE),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (SVC_START === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = '0;
    SVC_DONE = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  // Grant appears; checks id against scoreboard and one-hot GNT.
  task automatic check_grant(input string name, output logic [1:0] k);
    bit ok;
    wait_start(ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("[TB] FAIL %s_start: no SVC_START within 20 cycles, required one", name);
    end
    k = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd0;
    n_checks++;
    if (SVC_ID !== k || GNT !== (4'b0001 << k) || BUSY !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL %s_grant: id=%0d gnt=%b busy=%b, required id=%0d gnt=%b busy=1",
               name, SVC_ID, GNT, BUSY, k, 4'b0001 << k);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({ACK, GNT, SVC_START, SVC_ID, BUSY, ERR} !== 13'd0) begin
      n_fails++;
      $display("[TB] FAIL reset: ack=%b gnt=%b start=%b id=%0d busy=%b err=%b, required all 0",
               ACK, GNT, SVC_START, SVC_ID, BUSY, ERR);
    end
  endtask

  task automatic test_single();
    logic [1:0] k;
    REQ = 4'b0100;
    exp_q.push_back(2'd2);
    check_grant("single", k);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (SVC_START !== 1'b0 || GNT !== 4'b0100 || ACK !== 4'b0000) begin
        n_fails++;
        $display("[TB] FAIL single_hold: start=%b gnt=%b ack=%b, required 0/0100/0000",
                 SVC_START, GNT, ACK);
      end
    end
    SVC_DONE = 1'b1;
    step();
    SVC_DONE = 1'b0;
    n_checks++;
    if (ACK !== 4'b0100 || GNT !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL single_ack: ack=%b gnt=%b, required 0100/0000", ACK, GNT);
    end
    step();
    step();
    n_checks++;
    if (ACK !== 4'b0100 || BUSY !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL single_ack_hold: ack=%b busy=%b, required 0100/1", ACK, BUSY);
    end
    REQ = 4'b0000;
    step();
    n_checks++;
    if (ACK !== 4'b0000 || BUSY !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL single_release: ack=%b busy=%b, required 0000/0", ACK, BUSY);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] k;
    do_reset();
    REQ = 4'b1111;
    for (int j = 0; j < 5; j++) exp_q.push_back(2'(j % 4));
    for (int j = 0; j < 5; j++) begin
      check_grant("rr", k);
      SVC_DONE = 1'b1;
      step();
      SVC_DONE = 1'b0;
      n_checks++;
      if (ACK !== (4'b0001 << k) || GNT !== 4'b0000) begin
        n_fails++;
        $display("[TB] FAIL rr_ack: ack=%b gnt=%b, required %b/0000", ACK, GNT, 4'b0001 << k);
      end
      REQ[k] = 1'b0;
      step();
      n_checks++;
      if (ACK !== 4'b0000 || BUSY !== 1'b0 || GNT !== 4'b0000) begin
        n_fails++;
        $display("[TB] FAIL rr_release: ack=%b busy=%b gnt=%b, required idle", ACK, BUSY, GNT);
      end
      REQ[k] = 1'b1;
    end
  endtask

  task automatic test_priority();
    logic [1:0] k;
    REQ = 4'b0010;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    for (int j = 0; j < 3; j++) begin
      check_grant("prio", k);
      SVC_DONE = 1'b1;
      step();
      SVC_DONE = 1'b0;
      REQ[k] = 1'b0;
      if (j == 0) REQ[3] = 1'b1;
      if (j == 1) REQ[1] = 1'b1;
      step();
      n_checks++;
      if (BUSY !== 1'b0 || ACK !== 4'b0000) begin
        n_fails++;
        $display("[TB] FAIL prio_release: busy=%b ack=%b, required 0/0000", BUSY, ACK);
      end
    end
    REQ = 4'b0000;
  endtask

  task automatic test_spurious_done();
    logic [1:0] k;
    SVC_DONE = 1'b1;
    step();
    SVC_DONE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({ACK, GNT, SVC_START, BUSY} !== 10'd0) begin
        n_fails++;
        $display("[TB] FAIL idle_done: ack=%b gnt=%b start=%b busy=%b, required all 0",
                 ACK, GNT, SVC_START, BUSY);
      end
      step();
    end
    REQ = 4'b1000;
    exp_q.push_back(2'd3);
    check_grant("spur", k);
    SVC_DONE = 1'b1;
    step();
    step();
    SVC_DONE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ACK !== 4'b1000 || GNT !== 4'b0000 || BUSY !== 1'b1 || SVC_START !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL release_done: ack=%b gnt=%b busy=%b start=%b, required 1000/0000/1/0",
                 ACK, GNT, BUSY, SVC_START);
      end
      step();
    end
    REQ = 4'b0000;
    step();
  endtask

  task automatic test_abort();
    logic [1:0] k;
    REQ = 4'b0100;
    exp_q.push_back(2'd2);
    check_grant("abort", k);
    step();
    REQ = 4'b0000;
    step();
    step();
    n_checks++;
    if (GNT !== 4'b0100) begin
      n_fails++;
      $display("[TB] FAIL abort_hold: gnt=%b, required 0100", GNT);
    end
    SVC_DONE = 1'b1;
    step();
    SVC_DONE = 1'b0;
    n_checks++;
    if (ACK !== 4'b0100) begin
      n_fails++;
      $display("[TB] FAIL abort_ack: ack=%b, required 0100", ACK);
    end
    step();
    n_checks++;
    if (ACK !== 4'b0000 || BUSY !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL abort_release: ack=%b busy=%b, required 0000/0", ACK, BUSY);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] k;
    REQ = 4'b0100;
    exp_q.push_back(2'd2);
    check_grant("rstmid", k);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_checks++;
    if ({ACK, GNT, SVC_START, SVC_ID, BUSY, ERR} !== 13'd0) begin
      n_fails++;
      $display("[TB] FAIL reset_mid: ack=%b gnt=%b start=%b id=%0d busy=%b err=%b, required all 0",
               ACK, GNT, SVC_START, SVC_ID, BUSY, ERR);
    end
    REQ = 4'b1111;
    exp_q.push_back(2'd0);
    check_grant("rstmid_after", k);
    SVC_DONE = 1'b1;
    step();
    SVC_DONE = 1'b0;
    REQ = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    logic [1:0] k;
    REQ = 4'b0010;
    exp_q.push_back(2'd1);
    check_grant("tmo", k);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      step();
      n_checks++;
      if (ACK !== 4'b0000 || GNT !== 4'b0010 || ERR !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL tmo_wait: ack=%b gnt=%b err=%b, required 0000/0010/0", ACK, GNT, ERR);
      end
    end
    step();
    n_checks++;
    if (ACK !== 4'b0010 || GNT !== 4'b0000 || ERR !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL tmo_expire: ack=%b gnt=%b err=%b, required 0010/0000/1", ACK, GNT, ERR);
    end
    REQ = 4'b0000;
    step();
    REQ = 4'b0100;
    exp_q.push_back(2'd2);
    check_grant("tmo_next", k);
    SVC_DONE = 1'b1;
    step();
    SVC_DONE = 1'b0;
    REQ = 4'b0000;
    step();
    n_checks++;
    if (ERR !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL tmo_sticky: err=%b, required 1", ERR);
    end
    do_reset();
    n_checks++;
    if (ERR !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL tmo_err_reset: err=%b, required 0", ERR);
    end
    REQ = 4'b0001;
    exp_q.push_back(2'd0);
    check_grant("tmo_race", k);
    for (int i = 0; i < 7; i++) step();
    SVC_DONE = 1'b1;
    step();
    SVC_DONE = 1'b0;
    n_checks++;
    if (ACK !== 4'b0001 || ERR !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL tmo_done_wins: ack=%b err=%b, required 0001/0", ACK, ERR);
    end
    REQ = 4'b0000;
    step();
`else
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (ACK !== 4'b0000 || GNT !== 4'b0010 || ERR !== 1'b0 || BUSY !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL no_tmo_wait: ack=%b gnt=%b err=%b busy=%b, required 0000/0010/0/1",
               ACK, GNT, ERR, BUSY);
    end
    SVC_DONE = 1'b1;
    step();
    SVC_DONE = 1'b0;
    n_checks++;
    if (ACK !== 4'b0010 || ERR !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL no_tmo_ack: ack=%b err=%b, required 0010/0", ACK, ERR);
    end
    REQ = 4'b0000;
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_spurious_done();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
